// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================
// ring_pkg : shared widths and helpers for ring_switch_alloc
// Rev 1.0
// ============================================================
package ring_pkg;
  localparam int         FLIT_W       = 8;
  localparam int         NPORT        = 3;
  localparam int         SEL_W        = 5;
  localparam int         DEST_MSB     = 7;
  localparam int         DEST_LSB     = 6;
  localparam logic [1:0] DEST_ILLEGAL = 2'b11;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [1:0]        port_t;

  function automatic port_t next_port(input port_t p);
    return (p == port_t'(NPORT - 1)) ? port_t'(0) : port_t'(p + 2'd1);
  endfunction
endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================
// flit_fifo : DEPTH-entry flit FIFO, first-word-fall-through head
// Rev 1.0
// ============================================================
module flit_fifo
  import ring_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  logic  pop_i,
  input  flit_t data_i,
  output flit_t head_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  flit_t         mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule
`default_nettype wire

// File: rtl/ring_switch_alloc.sv
`default_nettype none
// ============================================================
// ring_switch_alloc : 3x3 credit-based switch allocator with
// per-output round-robin arbitration. Rev 1.0
// ============================================================
module ring_switch_alloc
  import ring_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in0,
  input  logic [FLIT_W-1:0] in1,
  input  logic [FLIT_W-1:0] in2,
  input  logic              in_valid0,
  input  logic              in_valid1,
  input  logic              in_valid2,
  output logic              in_ready0,
  output logic              in_ready1,
  output logic              in_ready2,
  output logic [FLIT_W-1:0] d0,
  output logic [FLIT_W-1:0] d1,
  output logic [FLIT_W-1:0] d2,
  output logic [SEL_W-1:0]  sel0,
  output logic [SEL_W-1:0]  sel1,
  output logic [SEL_W-1:0]  sel2,
  output logic              out_valid0,
  output logic              out_valid1,
  output logic              out_valid2,
  input  logic              credit_in0,
  input  logic              credit_in1,
  input  logic              credit_in2,
  output logic              drop
);
  localparam int CW = $clog2(CREDITS + 1);

  flit_t             in_a   [NPORT];
  flit_t             head_a [NPORT];
  logic [NPORT-1:0]  in_v, full, empty, pop, illegal, credit_in, granted_in;
  logic [NPORT-1:0]  gnt     [NPORT];
  port_t             dest    [NPORT];
  logic [CW-1:0]     credit_q [NPORT], credit_d [NPORT];
  port_t             ptr_q    [NPORT], ptr_d    [NPORT];
  flit_t             d_q      [NPORT], d_d      [NPORT];
  logic [SEL_W-1:0]  sel_q    [NPORT], sel_d    [NPORT];
  logic [NPORT-1:0]  ovalid_q, ovalid_d;
  logic              drop_q, drop_d;

  assign in_a[0] = in0;
  assign in_a[1] = in1;
  assign in_a[2] = in2;
  assign in_v      = {in_valid2, in_valid1, in_valid0};
  assign credit_in = {credit_in2, credit_in1, credit_in0};

  generate
    for (genvar n = 0; n < NPORT; n++) begin : g_fifo
      flit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_v[n]),
        .pop_i   (pop[n]),
        .data_i  (in_a[n]),
        .head_o  (head_a[n]),
        .full_o  (full[n]),
        .empty_o (empty[n])
      );
    end
  endgenerate

  always_comb begin
    port_t idx;
    logic  found;
    pop        = '0;
    illegal    = '0;
    granted_in = '0;
    idx        = '0;
    found      = 1'b0;
    for (int n = 0; n < NPORT; n++) begin
      dest[n]    = head_a[n][DEST_MSB:DEST_LSB];
      illegal[n] = !empty[n] && (dest[n] == DEST_ILLEGAL);
    end
    for (int m = 0; m < NPORT; m++) begin
      gnt[m] = '0;
      idx    = ptr_q[m];
      found  = 1'b0;
      // Scan inputs starting at this output's round-robin pointer.
      for (int k = 0; k < NPORT; k++) begin
        if (!found && !empty[idx] && dest[idx] == port_t'(m) && credit_q[m] != '0) begin
          gnt[m][idx] = 1'b1;
          found       = 1'b1;
        end
        idx = next_port(idx);
      end
    end
    for (int n = 0; n < NPORT; n++) begin
      for (int m = 0; m < NPORT; m++) granted_in[n] = granted_in[n] | gnt[m][n];
      pop[n] = illegal[n] | granted_in[n];
      d_d[n] = granted_in[n] ? head_a[n] : d_q[n];
    end
    for (int m = 0; m < NPORT; m++) begin
      ovalid_d[m] = |gnt[m];
      sel_d[m]    = {{(SEL_W-NPORT){1'b0}}, gnt[m]};
      ptr_d[m]    = ptr_q[m];
      for (int n = 0; n < NPORT; n++) begin
        if (gnt[m][n]) ptr_d[m] = next_port(port_t'(n));
      end
      credit_d[m] = credit_q[m];
      if (ovalid_d[m] && !credit_in[m])
        credit_d[m] = credit_q[m] - 1'b1;
      else if (credit_in[m] && !ovalid_d[m] && credit_q[m] != CW'(CREDITS))
        credit_d[m] = credit_q[m] + 1'b1;
    end
    drop_d = |illegal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPORT; i++) begin
        credit_q[i] <= CW'(CREDITS);
        ptr_q[i]    <= '0;
        d_q[i]      <= '0;
        sel_q[i]    <= '0;
      end
      ovalid_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        credit_q[i] <= credit_d[i];
        ptr_q[i]    <= ptr_d[i];
        d_q[i]      <= d_d[i];
        sel_q[i]    <= sel_d[i];
      end
      ovalid_q <= ovalid_d;
      drop_q   <= drop_d;
    end
  end

  assign in_ready0  = !full[0];
  assign in_ready1  = !full[1];
  assign in_ready2  = !full[2];
  assign d0         = d_q[0];
  assign d1         = d_q[1];
  assign d2         = d_q[2];
  assign sel0       = sel_q[0];
  assign sel1       = sel_q[1];
  assign sel2       = sel_q[2];
  assign out_valid0 = ovalid_q[0];
  assign out_valid1 = ovalid_q[1];
  assign out_valid2 = ovalid_q[2];
  assign drop       = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_ring_switch_alloc.sv
`default_nettype none
// ============================================================
// tb_ring_switch_alloc : directed, scoreboard-checked bench
// Rev 1.0
// ============================================================
module tb_ring_switch_alloc;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_d [3];
  logic       in_v [3];
  logic       cr   [3];
  logic [7:0] d0, d1, d2;
  logic [4:0] sel0, sel1, sel2;
  logic       ov0, ov1, ov2, rdy0, rdy1, rdy2, drop;

  logic [7:0] d_a   [3];
  logic [4:0] sel_a [3];
  logic       ov_a  [3];
  logic       rdy_a [3];
  assign d_a[0] = d0;     assign d_a[1] = d1;     assign d_a[2] = d2;
  assign sel_a[0] = sel0; assign sel_a[1] = sel1; assign sel_a[2] = sel2;
  assign ov_a[0] = ov0;   assign ov_a[1] = ov1;   assign ov_a[2] = ov2;
  assign rdy_a[0] = rdy0; assign rdy_a[1] = rdy1; assign rdy_a[2] = rdy2;

  always #5 clk = ~clk;

  ring_switch_alloc #(.DEPTH(4), .CREDITS(4)) dut (
    .clk(clk), .rst(rst),
    .in0(in_d[0]), .in1(in_d[1]), .in2(in_d[2]),
    .in_valid0(in_v[0]), .in_valid1(in_v[1]), .in_valid2(in_v[2]),
    .in_ready0(rdy0), .in_ready1(rdy1), .in_ready2(rdy2),
    .d0(d0), .d1(d1), .d2(d2),
    .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .out_valid0(ov0), .out_valid1(ov1), .out_valid2(ov2),
    .credit_in0(cr[0]), .credit_in1(cr[1]), .credit_in2(cr[2]),
    .drop(drop)
  );

  typedef struct packed {
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record a flit the bench expects to emerge, if the FIFO will take it.
  task automatic note(input int n, input logic [7:0] data, output bit acc);
    acc = rdy_a[n];
    if (acc && data[7:6] != 2'b11) sb.push_back('{data[7:6], 2'(n), data});
  endtask

  task automatic monitor();
    int   idx;
    exp_t e;
    for (int m = 0; m < 3; m++) begin
      if (ov_a[m]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].dst == 2'(m)) idx = i;
        if (idx < 0) begin
          chk("unexpected_grant_sel", 32'(sel_a[m]), 32'd0);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          chk("sb_sel", 32'(sel_a[m]), 32'd1 << e.src);
          chk("sb_data", 32'(d_a[e.src]), 32'(e.data));
        end
      end else if (sel_a[m] != 5'b0) begin
        chk("sel_without_valid", 32'(sel_a[m]), 32'd0);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic push1(input int n, input logic [7:0] data);
    bit acc;
    in_v[n] = 1'b1;
    in_d[n] = data;
    note(n, data, acc);
    step();
    in_v[n] = 1'b0;
  endtask

  function automatic int pending(input int m);
    int c = 0;
    for (int i = 0; i < sb.size(); i++) if (sb[i].dst == 2'(m)) c++;
    return c;
  endfunction

  initial begin
    bit acc;
    int accepted;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_d[i] = '0; in_v[i] = 1'b0; cr[i] = 1'b0;
    end
    #1;
    chk("rst_ready", {29'd0, rdy2, rdy1, rdy0}, 32'h7);
    chk("rst_valid", {29'd0, ov2, ov1, ov0}, 32'h0);
    chk("rst_sel", {17'd0, sel2, sel1, sel0}, 32'h0);
    chk("rst_data", {8'd0, d2, d1, d0}, 32'h0);
    chk("rst_drop", 32'(drop), 32'd0);
    step(); step();
    rst = 1'b0;

    // Single flit to output 2: visible one edge after the write edge.
    push1(0, 8'h81);
    chk("no_bypass_ov2", 32'(ov2), 32'd0);
    step();
    chk("first_sel2", 32'(sel2), 32'h01);
    chk("first_d0", 32'(d0), 32'h81);
    chk("first_ov2", 32'(ov2), 32'd1);

    // Three inputs contend for output 1: round-robin 0,1,2.
    for (int n = 0; n < 3; n++) begin
      in_v[n] = 1'b1; in_d[n] = 8'h41; note(n, 8'h41, acc);
    end
    step();
    for (int n = 0; n < 3; n++) in_v[n] = 1'b0;
    step();
    chk("rr_sel1_a", 32'(sel1), 32'h01);
    chk("rr_d0", 32'(d0), 32'h41);
    step();
    chk("rr_sel1_b", 32'(sel1), 32'h02);
    chk("rr_d1", 32'(d1), 32'h41);
    step();
    chk("rr_sel1_c", 32'(sel1), 32'h04);
    chk("rr_d2", 32'(d2), 32'h41);

    // Illegal destination is discarded with a single drop pulse.
    push1(0, 8'hC5);
    step();
    chk("drop_pulse", 32'(drop), 32'd1);
    chk("drop_nosel", {17'd0, sel2, sel1, sel0}, 32'h0);
    step();
    chk("drop_end", 32'(drop), 32'd0);
    chk("drop_ready0", 32'(rdy0), 32'd1);

    // Five flits to output 0 with four credits: fifth waits for a return.
    in_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_d[1] = 8'h05; note(1, 8'h05, acc); step();
    end
    in_v[1] = 1'b0;
    step(); step(); step();
    chk("credit0_block", 32'(ov0), 32'd0);
    chk("credit0_pending", 32'(pending(0)), 32'd1);
    cr[0] = 1'b1;
    step();
    cr[0] = 1'b0;
    chk("credit0_not_yet", 32'(ov0), 32'd0);
    step();
    chk("credit0_ov", 32'(ov0), 32'd1);
    chk("credit0_sel", 32'(sel0), 32'h02);
    chk("credit0_d1", 32'(d1), 32'h05);

    // Drain output 2 credits (one already used), then fill FIFO 2.
    push1(0, 8'h82);
    push1(0, 8'h83);
    push1(0, 8'h84);
    step(); step();
    accepted = 0;
    in_v[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_d[2] = 8'h90 + 8'(i);
      note(2, in_d[2], acc);
      if (acc) accepted++;
      step();
    end
    in_v[2] = 1'b0;
    chk("full_accepts", 32'(accepted), 32'd4);
    chk("full_ready2", 32'(rdy2), 32'd0);
    step(); step();
    chk("credit2_block", 32'(ov2), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cr[2] = 1'b1; step(); cr[2] = 1'b0; step(); step();
    end
    chk("drain_pending2", 32'(pending(2)), 32'd0);
    chk("drain_ready2", 32'(rdy2), 32'd1);

    // Asynchronous reset mid-cycle with flits buffered and a live grant.
    push1(0, 8'h8A);
    push1(0, 8'h8B);
    push1(1, 8'h42);
    step();
    chk("pre_rst_ov1", 32'(ov1), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {29'd0, ov2, ov1, ov0}, 32'h0);
    chk("arst_sel", {17'd0, sel2, sel1, sel0}, 32'h0);
    chk("arst_data", {8'd0, d2, d1, d0}, 32'h0);
    chk("arst_ready", {29'd0, rdy2, rdy1, rdy0}, 32'h7);
    sb.delete();
    step();
    rst = 1'b0;
    push1(0, 8'h81);
    step();
    chk("post_rst_d0", 32'(d0), 32'h81);
    chk("post_rst_sel2", 32'(sel2), 32'h01);
    in_v[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_d[1] = 8'h07; note(1, 8'h07, acc); step();
    end
    in_v[1] = 1'b0;
    step(); step();
    chk("post_rst_credits", 32'(pending(0)), 32'd1);
    cr[0] = 1'b1; step(); cr[0] = 1'b0; step(); step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
